// File: rtl/lnand_pulse_driver_if.sv
// Request/latch-side signal bundle for lnand_pulse_driver.
// slave = the pulse driver, master = requester plus latch feedback.
interface lnand_pulse_driver_if;
  logic req_valid;
  logic req_op;
  logic req_ready;
  logic sin;
  logic rin;
  logic q_fb;
  logic done;
  logic err;
  logic err_clr;

  modport master (
    output req_valid,
    output req_op,
    output q_fb,
    output err_clr,
    input  req_ready,
    input  sin,
    input  rin,
    input  done,
    input  err
  );

  modport slave (
    input  req_valid,
    input  req_op,
    input  q_fb,
    input  err_clr,
    output req_ready,
    output sin,
    output rin,
    output done,
    output err
  );
endinterface

// File: rtl/lnand_pulse_driver.sv
// Turns set/clear requests into width-guaranteed active-low SIN/RIN pulses
// for a NAND SR latch. Optional Q feedback check: define LNAND_QFB_CHECK_EN.
module lnand_pulse_driver #(
  parameter int PW_CYCLES  = 2,
  parameter int GAP_CYCLES = 1,
  parameter int CNT_W      = 4
) (
  input  logic                 clk,
  input  logic                 rst,
  lnand_pulse_driver_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    PULSE = 2'd1,
    GAP   = 2'd2
  } state_t;

  localparam logic [CNT_W-1:0] PW_LOAD  = CNT_W'(PW_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LOAD = CNT_W'(GAP_CYCLES - 1);

  state_t           state_reg, state_next;
  logic [CNT_W-1:0] cnt_reg, cnt_next;
  logic             op_reg, op_next;
  logic             sin_reg, sin_next;
  logic             rin_reg, rin_next;
  logic             ready_reg, ready_next;
  logic             done_reg, done_next;
  logic             gap_end;

  assign gap_end = (state_reg == GAP) && (cnt_reg == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      op_reg    <= 1'b0;
      sin_reg   <= 1'b1;
      rin_reg   <= 1'b1;
      ready_reg <= 1'b0;
      done_reg  <= 1'b0;
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      op_reg    <= op_next;
      sin_reg   <= sin_next;
      rin_reg   <= rin_next;
      ready_reg <= ready_next;
      done_reg  <= done_next;
    end
  end

  // Line drives are complementary only at acceptance and while pulsing,
  // so SIN and RIN can never be low together.
  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    op_next    = op_reg;
    sin_next   = 1'b1;
    rin_next   = 1'b1;
    ready_next = 1'b0;
    done_next  = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.req_valid && ready_reg) begin
          state_next = PULSE;
          cnt_next   = PW_LOAD;
          op_next    = bus.req_op;
          sin_next   = ~bus.req_op;
          rin_next   = bus.req_op;
        end else begin
          ready_next = 1'b1;
        end
      end
      PULSE: begin
        if (cnt_reg == '0) begin
          state_next = GAP;
          cnt_next   = GAP_LOAD;
        end else begin
          cnt_next = cnt_reg - 1'b1;
          sin_next = ~op_reg;
          rin_next = op_reg;
        end
      end
      GAP: begin
        if (cnt_reg == '0) begin
          state_next = IDLE;
          ready_next = 1'b1;
          done_next  = 1'b1;
        end else begin
          cnt_next = cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = IDLE;
        cnt_next   = '0;
      end
    endcase
  end

  assign bus.sin       = sin_reg;
  assign bus.rin       = rin_reg;
  assign bus.req_ready = ready_reg;
  assign bus.done      = done_reg;

`ifdef LNAND_QFB_CHECK_EN
  logic err_reg, err_next;

  // A fresh mismatch beats a simultaneous clear.
  always_comb begin
    err_next = err_reg;
    if (gap_end && (bus.q_fb != op_reg)) begin
      err_next = 1'b1;
    end else if (bus.err_clr) begin
      err_next = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      err_reg <= 1'b0;
    end else begin
      err_reg <= err_next;
    end
  end

  assign bus.err = err_reg;
`else
  logic unused_fb;
  assign unused_fb = bus.q_fb ^ bus.err_clr ^ gap_end;
  assign bus.err   = 1'b0;
`endif

endmodule
